outport_vc_scheduler_control_unit: RTL and testbench
====================================================

Name: outport_vc_scheduler_control_unit

Overview:
Control unit for one router output port that schedules whole packets across NUM_VC virtual channels under credit-based flow control. It keeps one credit counter per VC and selects one eligible VC per packet slot by round-robin. It sequences the outport arbiter (strobe/clear) and the winning link controller (transfer strobe) for exactly PACKET_FLITS cycles per packet. It sits between the input-port link controllers and the outport arbiter/crossbar select, as the multi-VC successor of the single-channel outport scheduler control.

Parameters:
NUM_VC, 2, number of virtual channels (1..8)
CREDITS, 4, buffer slots per VC in the downstream router; reset value of each credit counter (≥1)
PACKET_FLITS, 5, flits per packet; duration of ACTIVE in cycles (≥2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
request_din  in  NUM_VC  per-VC "any request pending" from link controllers
credit_in_din  in  NUM_VC  per-VC one-cycle pulse: downstream freed one packet slot
zero_credits_dout  out  NUM_VC  per-VC credit counter == 0
vc_grant_dout  out  NUM_VC  one-hot registered VC being served; all-zero when idle
arbiter_strobe_dout  out  1  capture current arbiter result (IDLE->ACTIVE cycle)
transfer_strobe_dout  out  1  registered pulse to the winner: start sending flits
clear_arbiter_dout  out  1  release arbiter result (last ACTIVE cycle)
busy_dout  out  1  state == ACTIVE
credit_error_dout  out  1  sticky credit-overflow flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state IDLE; all credit counters = CREDITS; RR pointer = VC0; flit counter = 0; vc_grant_dout=0, transfer_strobe_dout=0, busy_dout=0, credit_error_dout=0; zero_credits_dout=0; arbiter_strobe_dout and clear_arbiter_dout=0 (IDLE, nothing eligible is evaluated while reset low). Assertion mid-packet aborts immediately; no clear pulse is issued.
- eligible[i] = request_din[i] & (credit[i] != 0).
- FSM IDLE: if |eligible in cycle T: arbiter_strobe_dout=1 (combinational, cycle T); winner = first eligible VC at or after RR pointer, wrapping NUM_VC-1 -> 0; at edge end of T: credit[winner]-1, vc_grant<=onehot(winner), RR pointer<=winner+1 mod NUM_VC, flit counter<=PACKET_FLITS-1, state<=ACTIVE.
- FSM ACTIVE (cycles T+1..T+PACKET_FLITS): transfer_strobe_dout=1 only at T+1; flit counter decrements each cycle; when counter==0 (cycle T+PACKET_FLITS): clear_arbiter_dout=1, next state IDLE, vc_grant<=0. Requests and eligibility are ignored while ACTIVE.
- Minimum one IDLE cycle between packets; packet period ≥ PACKET_FLITS+1 cycles.
- Credit counter width clog2(CREDITS+1). Per VC per cycle: inc on credit_in_din, dec on grant; both at once -> unchanged. Inc at CREDITS with no dec -> saturate at CREDITS (overflow event). Dec is impossible at 0 by eligibility.
- Credits return on any VC at any time, including ACTIVE; zero_credits_dout reflects the registered counters.

Optional Feature:
OUTPORT_CREDIT_CHECK_EN: defined -> an overflow event (credit_in on a saturated counter without simultaneous dec) sets credit_error_dout, sticky until reset; `ifdef SIMULATION also $error with VC index. Undefined -> credit_error_dout tied 0, no check logic; saturation still applies.

Decomposition:
- Shared package/header (system.vh): clog2 function, default NUM_VC, CREDITS, PACKET_FLITS, PE-port CREDITS override constant, FSM state encodings IDLE/ACTIVE.
- One sub-module: vc_credit_counter (one instance per VC via generate; inc/dec/saturate/zero flag/overflow event). RR selection and FSM stay in the top.

Test Plan:
- Reset then request_din=2'b01 at T -> arbiter_strobe at T; transfer_strobe at T+1; vc_grant=01 T+1..T+5; clear_arbiter at T+5; credit[0]=3.
- request_din=2'b11 held, no credit returns -> grants VC0,VC1,VC0,VC1,... each 6 cycles apart; after 8 packets both zero_credits=1, no further arbiter_strobe.
- VC0 credit=0, request_din=2'b11 -> VC1 granted regardless of RR pointer; credit_in_din[0] pulse -> VC0 eligible next IDLE.
- credit_in_din[1] in the same cycle VC1 is granted with credit[1]=2 -> credit[1] stays 2.
- credit_in_din[0] with credit[0]=4 -> counter stays 4; credit_error_dout=1 with OUTPORT_CREDIT_CHECK_EN, 0 without.
- reset low at ACTIVE cycle 3 -> outputs to reset values immediately, no clear_arbiter; after release, new packet starts normally with credits=4.

Source files
------------

// File: rtl/outport_vc_scheduler_control_unit_pkg.sv
// Shared definitions for the multi-VC outport scheduler control unit.
//   clog2              : ceiling log2 helper for counter and pointer widths
//   DEFAULT_*          : default NUM_VC / CREDITS / PACKET_FLITS
//   PE_PORT_CREDITS    : credit depth used on processing-element facing ports
//   state_t            : scheduler FSM states (IDLE / ACTIVE)
package outport_vc_scheduler_control_unit_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    localparam int unsigned DEFAULT_NUM_VC       = 2;
    localparam int unsigned DEFAULT_CREDITS      = 4;
    localparam int unsigned DEFAULT_PACKET_FLITS = 5;
    localparam int unsigned PE_PORT_CREDITS      = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/outport_vc_scheduler_control_unit_vc_credit_counter.sv
// Per-VC downstream credit counter.
//   clk, reset  : clock, asynchronous active-low reset (count -> CREDITS)
//   inc_i       : downstream freed one packet slot
//   dec_i       : this VC was granted a packet slot
//   zero_o      : registered count == 0
//   overflow_o  : inc on a saturated counter without simultaneous dec
module vc_credit_counter
    import outport_vc_scheduler_control_unit_pkg::*;
#(
    parameter int unsigned CREDITS = DEFAULT_CREDITS,
    parameter int unsigned CW      = clog2(CREDITS + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic overflow_o
);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d    = count_q;
        overflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q == CW'(CREDITS)) overflow_o = 1'b1;
            else                         count_d    = count_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= CW'(CREDITS);
        else        count_q <= count_d;
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/outport_vc_scheduler_control_unit.sv
// Multi-VC output port scheduler control: picks one eligible VC per packet
// slot by round-robin, tracks per-VC credits, and sequences the arbiter and
// the winning link controller for PACKET_FLITS cycles per packet.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   request_din[NUM_VC]   : per-VC request pending
//   credit_in_din[NUM_VC] : per-VC credit return pulse
//   zero_credits_dout     : per-VC credit counter == 0
//   vc_grant_dout         : one-hot VC being served (0 when idle)
//   arbiter_strobe_dout   : capture arbiter result (IDLE -> ACTIVE cycle)
//   transfer_strobe_dout  : first ACTIVE cycle pulse to the winner
//   clear_arbiter_dout    : last ACTIVE cycle
//   busy_dout             : FSM is ACTIVE
//   credit_error_dout     : sticky credit overflow flag
// Optional: OUTPORT_CREDIT_CHECK_EN enables the sticky overflow flag
// (plus a $error under SIMULATION); otherwise the flag is tied low.
module outport_vc_scheduler_control_unit
    import outport_vc_scheduler_control_unit_pkg::*;
#(
    parameter int unsigned NUM_VC       = DEFAULT_NUM_VC,
    parameter int unsigned CREDITS      = DEFAULT_CREDITS,
    parameter int unsigned PACKET_FLITS = DEFAULT_PACKET_FLITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_VC-1:0] request_din,
    input  logic [NUM_VC-1:0] credit_in_din,
    output logic [NUM_VC-1:0] zero_credits_dout,
    output logic [NUM_VC-1:0] vc_grant_dout,
    output logic              arbiter_strobe_dout,
    output logic              transfer_strobe_dout,
    output logic              clear_arbiter_dout,
    output logic              busy_dout,
    output logic              credit_error_dout
);

    localparam int unsigned FW = clog2(PACKET_FLITS);
    localparam int unsigned PW = (NUM_VC > 1) ? clog2(NUM_VC) : 1;

    state_t            state_q, state_d;
    logic [FW-1:0]     flit_q, flit_d;
    logic [PW-1:0]     rr_q, rr_d;
    logic [NUM_VC-1:0] grant_q, grant_d;
    logic              xfer_q, xfer_d;

    logic [NUM_VC-1:0] zero_w, overflow_w, dec_w, eligible;
    logic [PW-1:0]     winner, idx_p;
    logic              found;
    int unsigned       idx;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_credit_counter #(
            .CREDITS(CREDITS)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc_i     (credit_in_din[g]),
            .dec_i     (dec_w[g]),
            .zero_o    (zero_w[g]),
            .overflow_o(overflow_w[g])
        );
    end

    assign eligible = request_din & ~zero_w;

    // First eligible VC scanning upward from the RR pointer, with wrap.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_p  = '0;
        for (int unsigned k = 0; k < NUM_VC; k++) begin
            idx   = (32'(rr_q) + k) % NUM_VC;
            idx_p = PW'(idx);
            if (!found && eligible[idx_p]) begin
                found  = 1'b1;
                winner = idx_p;
            end
        end
    end

    // Reset is qualified in so nothing is strobed while reset is held low.
    always_comb begin
        state_d             = state_q;
        flit_d              = flit_q;
        rr_d                = rr_q;
        grant_d             = grant_q;
        xfer_d              = 1'b0;
        dec_w               = '0;
        arbiter_strobe_dout = 1'b0;
        clear_arbiter_dout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && reset) begin
                    arbiter_strobe_dout = 1'b1;
                    state_d             = ACTIVE;
                    flit_d              = FW'(PACKET_FLITS - 1);
                    grant_d             = '0;
                    grant_d[winner]     = 1'b1;
                    dec_w[winner]       = 1'b1;
                    xfer_d              = 1'b1;
                    rr_d = (winner == PW'(NUM_VC - 1)) ? '0 : winner + 1'b1;
                end
            end
            ACTIVE: begin
                if (flit_q == '0) begin
                    clear_arbiter_dout = 1'b1;
                    state_d            = IDLE;
                    grant_d            = '0;
                end else begin
                    flit_d = flit_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            flit_q  <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            xfer_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            xfer_q  <= xfer_d;
        end
    end

    assign zero_credits_dout    = zero_w;
    assign vc_grant_dout        = grant_q;
    assign transfer_strobe_dout = xfer_q;
    assign busy_dout            = (state_q == ACTIVE);

`ifdef OUTPORT_CREDIT_CHECK_EN
    logic err_q, err_d;

    always_comb err_d = err_q | (|overflow_w);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_VC; i++)
            if (reset && overflow_w[i]) $error("credit overflow on VC %0d", i);
    end
`endif

    assign credit_error_dout = err_q;
`else
    logic unused_overflow;
    assign unused_overflow   = ^overflow_w;
    assign credit_error_dout = 1'b0;
`endif

endmodule

// File: tb/tb_outport_vc_scheduler_control_unit.sv
module tb_outport_vc_scheduler_control_unit;

    localparam int PF = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] request_din = '0;
    logic [1:0] credit_in_din = '0;
    logic [1:0] zero_credits_dout, vc_grant_dout;
    logic       arbiter_strobe_dout, transfer_strobe_dout, clear_arbiter_dout;
    logic       busy_dout, credit_error_dout;

    outport_vc_scheduler_control_unit #(
        .NUM_VC(2),
        .CREDITS(4),
        .PACKET_FLITS(PF)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .request_din         (request_din),
        .credit_in_din       (credit_in_din),
        .zero_credits_dout   (zero_credits_dout),
        .vc_grant_dout       (vc_grant_dout),
        .arbiter_strobe_dout (arbiter_strobe_dout),
        .transfer_strobe_dout(transfer_strobe_dout),
        .clear_arbiter_dout  (clear_arbiter_dout),
        .busy_dout           (busy_dout),
        .credit_error_dout   (credit_error_dout)
    );

    always #5 clk = ~clk;

`ifdef OUTPORT_CREDIT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int mon_v;
    int arbs, last;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [1:0] cin;
        logic [1:0] grant;
        logic       arb;
        logic       xfer;
        logic       clr;
        logic       busy;
        logic [1:0] zero;
        logic       err;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are looked at 1 time unit later.
    task automatic drive(input logic r, input logic [1:0] req, input logic [1:0] cin);
        @(negedge clk);
        reset         = r;
        request_din   = req;
        credit_in_din = cin;
        #1;
    endtask

    task automatic packet(input logic [1:0] req, input logic [1:0] cin, input int vc, input string nm);
        drive(1'b1, req, cin);
        check({nm, "_arb"}, 32'(arbiter_strobe_dout), 32'd1);
        exp_q.push_back(vc);
        for (int k = 0; k < PF; k++) drive(1'b1, 2'b00, 2'b00);
        check({nm, "_clr"}, 32'(clear_arbiter_dout), 32'd1);
    endtask

    // Scoreboard: every transfer strobe must present the next expected grant.
    always begin
        @(negedge clk);
        #2;
        if (reset === 1'b1 && transfer_strobe_dout === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: transfer strobe with grant %0h, none expected", vc_grant_dout);
            end else begin
                mon_v = exp_q.pop_front();
                check("sb_grant", 32'(vc_grant_dout), 32'd1 << mon_v);
            end
        end
    end

    initial begin
        //            rst   req    cin    grant  arb   xfer  clr   busy  zero   err
        tbl[0]  = '{1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[1]  = '{1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[2]  = '{1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0};
        tbl[3]  = '{1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        tbl[4]  = '{1'b1, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        tbl[5]  = '{1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0};
        tbl[6]  = '{1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
        tbl[7]  = '{1'b1, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[8]  = '{1'b1, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
        tbl[9]  = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, EXP_ERR};
        tbl[10] = '{1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, EXP_ERR};

        // Single packet on VC0, then credit return to full and an overflow.
        exp_q.push_back(0);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].cin);
            check($sformatf("v%0d_grant", i), 32'(vc_grant_dout), 32'(tbl[i].grant));
            check($sformatf("v%0d_arb", i), 32'(arbiter_strobe_dout), 32'(tbl[i].arb));
            check($sformatf("v%0d_xfer", i), 32'(transfer_strobe_dout), 32'(tbl[i].xfer));
            check($sformatf("v%0d_clr", i), 32'(clear_arbiter_dout), 32'(tbl[i].clr));
            check($sformatf("v%0d_busy", i), 32'(busy_dout), 32'(tbl[i].busy));
            check($sformatf("v%0d_zero", i), 32'(zero_credits_dout), 32'(tbl[i].zero));
            check($sformatf("v%0d_err", i), 32'(credit_error_dout), 32'(tbl[i].err));
        end

        // Both VCs requesting continuously: strict alternation until credits run out.
        drive(1'b0, 2'b00, 2'b00);
        check("b_err_cleared", 32'(credit_error_dout), 32'd0);
        drive(1'b1, 2'b00, 2'b00);
        for (int k = 0; k < 8; k++) exp_q.push_back(k % 2);
        arbs = 0;
        last = -1;
        for (int c = 0; c < 100 && arbs < 8; c++) begin
            drive(1'b1, 2'b11, 2'b00);
            if (arbiter_strobe_dout === 1'b1) begin
                if (last >= 0) check("b_period", 32'(c - last), 32'd6);
                last = c;
                arbs++;
            end
        end
        check("b_packets", 32'(arbs), 32'd8);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 2'b11, 2'b00);
            check("b_no_arb", 32'(arbiter_strobe_dout), 32'd0);
        end
        check("b_zero", 32'(zero_credits_dout), 32'd3);
        check("b_queue", 32'(exp_q.size()), 32'd0);

        // RR pointer is at VC0, but only VC1 has a credit back.
        drive(1'b1, 2'b11, 2'b10);
        check("c_no_elig", 32'(arbiter_strobe_dout), 32'd0);
        drive(1'b1, 2'b11, 2'b00);
        check("c_vc1_arb", 32'(arbiter_strobe_dout), 32'd1);
        exp_q.push_back(1);
        drive(1'b1, 2'b11, 2'b01);
        check("c_zero_t1", 32'(zero_credits_dout), 32'd3);
        drive(1'b1, 2'b11, 2'b00);
        check("c_zero_t2", 32'(zero_credits_dout), 32'd2);
        for (int k = 0; k < 3; k++) drive(1'b1, 2'b11, 2'b00);
        check("c_clr", 32'(clear_arbiter_dout), 32'd1);
        drive(1'b1, 2'b11, 2'b00);
        check("c_vc0_arb", 32'(arbiter_strobe_dout), 32'd1);
        exp_q.push_back(0);
        for (int k = 0; k < PF; k++) drive(1'b1, 2'b00, 2'b00);
        check("c_clr2", 32'(clear_arbiter_dout), 32'd1);

        // Credit return coinciding with a grant leaves VC1's count unchanged.
        drive(1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b00, 2'b00);
        packet(2'b10, 2'b00, 1, "d1");
        packet(2'b10, 2'b00, 1, "d2");
        packet(2'b10, 2'b10, 1, "d3");
        check("d_zero_after3", 32'(zero_credits_dout), 32'd0);
        packet(2'b10, 2'b00, 1, "d4");
        check("d_zero_after4", 32'(zero_credits_dout), 32'd0);
        packet(2'b10, 2'b00, 1, "d5");
        check("d_zero_after5", 32'(zero_credits_dout), 32'd2);

        // Reset mid-packet aborts without a clear pulse; credits come back full.
        drive(1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b00, 2'b00);
        drive(1'b1, 2'b01, 2'b00);
        check("e_arb", 32'(arbiter_strobe_dout), 32'd1);
        exp_q.push_back(0);
        drive(1'b1, 2'b00, 2'b00);
        drive(1'b1, 2'b00, 2'b00);
        drive(1'b0, 2'b01, 2'b00);
        check("e_rst_grant", 32'(vc_grant_dout), 32'd0);
        check("e_rst_busy", 32'(busy_dout), 32'd0);
        check("e_rst_clr", 32'(clear_arbiter_dout), 32'd0);
        check("e_rst_arb", 32'(arbiter_strobe_dout), 32'd0);
        check("e_rst_xfer", 32'(transfer_strobe_dout), 32'd0);
        drive(1'b0, 2'b00, 2'b00);
        drive(1'b1, 2'b00, 2'b00);
        packet(2'b01, 2'b00, 0, "e1");
        packet(2'b01, 2'b00, 0, "e2");
        packet(2'b01, 2'b00, 0, "e3");
        check("e_zero_after3", 32'(zero_credits_dout), 32'd0);
        packet(2'b01, 2'b00, 0, "e4");
        check("e_zero_after4", 32'(zero_credits_dout), 32'd1);

        drive(1'b1, 2'b00, 2'b00);
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
